// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions: default geometry and Gray/binary conversions
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_PTR_W    = FIFO_ADDRSIZE + 1;

  // Widest pointer any legal ADDRSIZE (2..12) can produce; callers zero-extend
  // into this width and truncate the result back to their own pointer width.
  localparam int PTR_W_MAX     = 13;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b = '0;
    for (int i = PTR_W_MAX - 1; i >= 0; i--) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter of arbitrary width.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[W-1:gi];
  end

endmodule

// File: rtl/wptr_full_gen.sv
// Write-side FIFO pointer block: binary/Gray write pointer, registered full,
// almost-full, fill level and sticky overflow, all in the write clock domain.
module wptr_full_gen
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PTR_W = ADDRSIZE + 1;
  localparam int DEPTH = 2 ** ADDRSIZE;

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gray;
  logic             r_full;
  logic             r_afull;
  logic [PTR_W-1:0] r_level;
  logic             r_ovf;

  logic             w_inc;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_full_pattern;
  logic             w_full_next;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] w_thresh_eff;
  logic             w_afull_next;
  logic             w_ovf_next;

  gray2bin #(
    .W (PTR_W)
  ) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  assign w_inc       = winc & ~r_full;
  assign w_bin_next  = r_bin + PTR_W'(w_inc);
  assign w_gray_next = PTR_W'(bin2gray(PTR_W_MAX'(w_bin_next)));

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that is the read pointer with its two MSBs inverted.
  assign w_full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  assign w_full_next    = (w_gray_next == w_full_pattern);

  assign w_level_next = w_bin_next - w_rbin;
  assign w_thresh_eff = (afull_thresh > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : afull_thresh;
  assign w_afull_next = (afull_thresh != '0) && (w_level_next >= w_thresh_eff);

  // A rejected write sets the flag even if a clear arrives on the same edge.
  assign w_ovf_next = (winc & r_full) ? 1'b1 : (wclr_ovf ? 1'b0 : r_ovf);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      r_level <= w_level_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign waddr        = r_bin[ADDRSIZE-1:0];
  assign wptr         = r_gray;
  assign wen          = w_inc;
  assign wfull        = r_full;
  assign walmost_full = r_afull;
  assign wlevel       = r_level;
  assign wovf         = r_ovf;

endmodule
